// File: rtl/jolt160_byte_mem_ctrl_if.sv
// CPU-side data bus of the jolt160 byte memory controller.
// The controller takes the slave view; the CPU (or a bench) takes the master view.
interface jolt160_byte_mem_ctrl_if #(
   parameter int unsigned CPU_ADDR_MSB_POS = 15
);
   logic                      req_rdwr;
   logic [CPU_ADDR_MSB_POS:0] addr_in;
   logic                      data_acc_sz;
   logic                      data_inout_we;
   logic [15:0]               write_data_in;
   logic [15:0]               read_data_out;
   logic                      data_ready;
   logic                      busy;

   modport slave (
      input  req_rdwr, addr_in, data_acc_sz, data_inout_we, write_data_in,
      output read_data_out, data_ready, busy
   );

   modport master (
      output req_rdwr, addr_in, data_acc_sz, data_inout_we, write_data_in,
      input  read_data_out, data_ready, busy
   );
endinterface

// File: rtl/jolt160_byte_mem_ctrl.sv
// Byte-wide RAM controller for the jolt160 data bus. An 8-bit access is one byte
// phase, a 16-bit access is two (low byte at addr, high byte at addr+1, wrapping).
// Write phases last one cycle; read phases last READ_LATENCY+1 cycles.
module jolt160_byte_mem_ctrl #(
   parameter int unsigned READ_LATENCY     = 1,
   parameter int unsigned CPU_ADDR_MSB_POS = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   jolt160_byte_mem_ctrl_if.slave    cpu,
   output logic [CPU_ADDR_MSB_POS:0] ram_addr,
   output logic [7:0]                ram_data_out,
   output logic                      ram_we,
   input  logic [7:0]                ram_data_in
);
   // Access size encoding on data_acc_sz.
   localparam logic CPU_DATA_ACC_SZ_16 = 1'b1;
   localparam int unsigned AW = CPU_ADDR_MSB_POS + 1;

   typedef enum logic [1:0] {StIdle, StByte0, StByte1, StDone} state_e;

   state_e          state_q, state_d;
   logic            req_q;
   logic [1:0]      cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            sz16_q, sz16_d;
   logic            we_q, we_d;
   logic [15:0]     wdata_q, wdata_d;
   logic [7:0]      lo_q, lo_d;
   logic [15:0]     rdata_q, rdata_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic [7:0]      ram_dout_q, ram_dout_d;
   logic            ram_we_q, ram_we_d;
   logic            req_edge;
   logic            phase_end;

   assign req_edge  = cpu.req_rdwr & ~req_q;
   // Writes take one cycle; reads end once the RAM latency has elapsed.
   assign phase_end = we_q | (cnt_q == 2'(READ_LATENCY));

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         req_q      <= 1'b1;
         cnt_q      <= '0;
         addr_q     <= '0;
         sz16_q     <= 1'b0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         lo_q       <= '0;
         rdata_q    <= '0;
         ram_addr_q <= '0;
         ram_dout_q <= '0;
         ram_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= cpu.req_rdwr;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         sz16_q     <= sz16_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         lo_q       <= lo_d;
         rdata_q    <= rdata_d;
         ram_addr_q <= ram_addr_d;
         ram_dout_q <= ram_dout_d;
         ram_we_q   <= ram_we_d;
      end
   end

   // Next-state and RAM-side register values; RAM strobes are set up on phase entry.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      sz16_d     = sz16_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      lo_d       = lo_q;
      rdata_d    = rdata_q;
      ram_addr_d = ram_addr_q;
      ram_dout_d = ram_dout_q;
      ram_we_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_edge) begin
               state_d    = StByte0;
               cnt_d      = '0;
               addr_d     = cpu.addr_in;
               sz16_d     = (cpu.data_acc_sz == CPU_DATA_ACC_SZ_16);
               we_d       = cpu.data_inout_we;
               wdata_d    = cpu.write_data_in;
               ram_addr_d = cpu.addr_in;
               if (cpu.data_inout_we) begin
                  ram_we_d   = 1'b1;
                  ram_dout_d = cpu.write_data_in[7:0];
               end
            end
         end
         StByte0: begin
            if (!phase_end) begin
               cnt_d = cnt_q + 2'd1;
            end else if (sz16_q) begin
               state_d    = StByte1;
               cnt_d      = '0;
               lo_d       = ram_data_in;
               ram_addr_d = addr_q + AW'(1);
               if (we_q) begin
                  ram_we_d   = 1'b1;
                  ram_dout_d = wdata_q[15:8];
               end
            end else begin
               state_d = StDone;
               if (!we_q) rdata_d = {8'h00, ram_data_in};
            end
         end
         StByte1: begin
            if (!phase_end) begin
               cnt_d = cnt_q + 2'd1;
            end else begin
               state_d = StDone;
               if (!we_q) rdata_d = {ram_data_in, lo_q};
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Reset also masks the strobes in the cycle it is asserted, so an aborted
   // access never completes a RAM write or signals completion.
   assign ram_we            = ram_we_q & ~reset;
   assign ram_addr          = ram_addr_q;
   assign ram_data_out      = ram_dout_q;
   assign cpu.read_data_out = rdata_q;
   assign cpu.data_ready    = (state_q == StDone) & ~reset;
   assign cpu.busy          = (state_q != StIdle);
endmodule

// File: tb/tb_jolt160_byte_mem_ctrl.sv
// Directed bench: two controllers (READ_LATENCY 1 and 2) driven with identical
// CPU stimulus, each attached to its own byte RAM model.
module tb_jolt160_byte_mem_ctrl;
   localparam int unsigned LAT_A = 1;
   localparam int unsigned LAT_B = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   jolt160_byte_mem_ctrl_if #(.CPU_ADDR_MSB_POS(15)) bus_a ();
   jolt160_byte_mem_ctrl_if #(.CPU_ADDR_MSB_POS(15)) bus_b ();

   logic [15:0] ram_addr_a, ram_addr_b;
   logic [7:0]  rdo_a, rdo_b, rdi_a, rdi_b;
   logic        we_a, we_b;

   jolt160_byte_mem_ctrl #(.READ_LATENCY(LAT_A), .CPU_ADDR_MSB_POS(15)) dut_a (
      .clk(clk), .reset(reset), .cpu(bus_a.slave), .ram_addr(ram_addr_a),
      .ram_data_out(rdo_a), .ram_we(we_a), .ram_data_in(rdi_a)
   );
   jolt160_byte_mem_ctrl #(.READ_LATENCY(LAT_B), .CPU_ADDR_MSB_POS(15)) dut_b (
      .clk(clk), .reset(reset), .cpu(bus_b.slave), .ram_addr(ram_addr_b),
      .ram_data_out(rdo_b), .ram_we(we_b), .ram_data_in(rdi_b)
   );

   // Synchronous byte RAMs: data for an address appears LAT cycles after it is presented.
   logic [7:0] mem_a [0:65535];
   logic [7:0] mem_b [0:65535];
   logic [7:0] pipe_a [0:2];
   logic [7:0] pipe_b [0:2];
   always @(posedge clk) begin
      if (we_a) mem_a[ram_addr_a] <= rdo_a;
      if (we_b) mem_b[ram_addr_b] <= rdo_b;
      pipe_a[0] <= mem_a[ram_addr_a];
      pipe_a[1] <= pipe_a[0];
      pipe_a[2] <= pipe_a[1];
      pipe_b[0] <= mem_b[ram_addr_b];
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign rdi_a = pipe_a[LAT_A-1];
   assign rdi_b = pipe_b[LAT_B-1];

   int errors = 0;
   int checks = 0;
   int rdy_a, rdy_b, n_a, n_b;
   logic [15:0] rd_a, rd_b;
   logic        log_we   [0:15];
   logic [15:0] log_addr [0:15];
   logic [7:0]  log_dout [0:15];
   logic        log_busy [0:15];
   logic [7:0]  prev;
   logic        bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic r);
      bus_a.req_rdwr = r;
      bus_b.req_rdwr = r;
   endtask

   task automatic set_bus(input logic sz16, input logic we, input logic [15:0] a,
                          input logic [15:0] wd);
      bus_a.data_acc_sz = sz16;  bus_b.data_acc_sz = sz16;
      bus_a.data_inout_we = we;  bus_b.data_inout_we = we;
      bus_a.addr_in = a;         bus_b.addr_in = a;
      bus_a.write_data_in = wd;  bus_b.write_data_in = wd;
   endtask

   // One request; cycle 0 is the cycle req rises. mode 1: req dips in cycle 1 and
   // rises again in cycle 2. mode 2: reset is asserted during cycle 2.
   task automatic txn(input logic sz16, input logic we, input logic [15:0] a,
                      input logic [15:0] wd, input int mode);
      n_a = 0; n_b = 0; rdy_a = -1; rdy_b = -1; rd_a = '0; rd_b = '0;
      set_bus(sz16, we, a, wd);
      for (int c = 0; c < 14; c++) begin
         set_req(!(mode == 1 && c == 1));
         reset = (mode == 2 && c == 2);
         @(negedge clk);
         log_we[c] = we_a; log_addr[c] = ram_addr_a; log_dout[c] = rdo_a;
         log_busy[c] = bus_a.busy;
         if (bus_a.data_ready) begin n_a++; rdy_a = c; rd_a = bus_a.read_data_out; end
         if (bus_b.data_ready) begin n_b++; rdy_b = c; rd_b = bus_b.read_data_out; end
         @(posedge clk); #1;
      end
      set_req(1'b0);
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      set_req(1'b1);
      set_bus(1'b0, 1'b1, 16'h0000, 16'h0000);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // req held high through reset must not start an access.
      @(negedge clk);
      chk("rst_busy", {31'b0, bus_a.busy}, 32'h0);
      chk("rst_ready", {31'b0, bus_a.data_ready}, 32'h0);
      chk("rst_we", {31'b0, we_a}, 32'h0);
      chk("rst_rdata", {16'b0, bus_a.read_data_out}, 32'h0);
      chk("rst_addr", {16'b0, ram_addr_a}, 32'h0);
      chk("rst_dout", {24'b0, rdo_a}, 32'h0);
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (we_a || we_b || bus_a.data_ready || bus_b.data_ready || bus_a.busy) bad = 1'b1;
      end
      chk("rst_held_req_ignored", {31'b0, bad}, 32'h0);
      @(posedge clk); #1 set_req(1'b0);
      @(posedge clk); #1;

      // 16-bit write 0x1234 <= 0xBEEF
      txn(1'b1, 1'b1, 16'h1234, 16'hBEEF, 0);
      chk("w16_we_c1", {31'b0, log_we[1]}, 32'h1);
      chk("w16_addr_c1", {16'b0, log_addr[1]}, 32'h1234);
      chk("w16_dout_c1", {24'b0, log_dout[1]}, 32'hEF);
      chk("w16_we_c2", {31'b0, log_we[2]}, 32'h1);
      chk("w16_addr_c2", {16'b0, log_addr[2]}, 32'h1235);
      chk("w16_dout_c2", {24'b0, log_dout[2]}, 32'hBE);
      chk("w16_we_c3", {31'b0, log_we[3]}, 32'h0);
      chk("w16_rdy_a", rdy_a, 3);
      chk("w16_nrdy_a", n_a, 1);
      chk("w16_rdy_b", rdy_b, 3);
      chk("w16_busy_c0", {31'b0, log_busy[0]}, 32'h0);
      chk("w16_busy_c1", {31'b0, log_busy[1]}, 32'h1);
      chk("w16_busy_c3", {31'b0, log_busy[3]}, 32'h1);
      chk("w16_busy_c4", {31'b0, log_busy[4]}, 32'h0);
      chk("w16_mem_lo", {24'b0, mem_a[16'h1234]}, 32'hEF);
      chk("w16_mem_hi", {24'b0, mem_a[16'h1235]}, 32'hBE);

      // 16-bit read 0x1234
      txn(1'b1, 1'b0, 16'h1234, 16'h0000, 0);
      chk("r16_we", {31'b0, log_we[1]}, 32'h0);
      chk("r16_rdy_a", rdy_a, 5);
      chk("r16_data_a", {16'b0, rd_a}, 32'hBEEF);
      chk("r16_rdy_b", rdy_b, 7);
      chk("r16_data_b", {16'b0, rd_b}, 32'hBEEF);

      // 8-bit read 0x1235
      txn(1'b0, 1'b0, 16'h1235, 16'h0000, 0);
      chk("r8_rdy_a", rdy_a, 3);
      chk("r8_data_a", {16'b0, rd_a}, 32'h00BE);
      chk("r8_rdy_b", rdy_b, 4);
      chk("r8_data_b", {16'b0, rd_b}, 32'h00BE);

      // 8-bit write leaves read_data_out alone and writes only one byte
      prev = mem_a[16'h0011];
      txn(1'b0, 1'b1, 16'h0010, 16'h1177, 0);
      chk("w8_rdy_a", rdy_a, 2);
      chk("w8_rdy_b", rdy_b, 2);
      chk("w8_rdata_hold", {16'b0, bus_a.read_data_out}, 32'h00BE);
      chk("w8_mem", {24'b0, mem_a[16'h0010]}, 32'h77);
      chk("w8_mem_next", {24'b0, mem_a[16'h0011]}, {24'b0, prev});

      // 16-bit write at 0xFFFF wraps to 0x0000
      txn(1'b1, 1'b1, 16'hFFFF, 16'hA55A, 0);
      chk("wrap_addr_c2", {16'b0, log_addr[2]}, 32'h0000);
      chk("wrap_mem_ffff", {24'b0, mem_a[16'hFFFF]}, 32'h5A);
      chk("wrap_mem_0000", {24'b0, mem_a[16'h0000]}, 32'hA5);
      chk("wrap_mem_b_0000", {24'b0, mem_b[16'h0000]}, 32'hA5);
      txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0);
      chk("wrap_rd_a", {16'b0, rd_a}, 32'hA55A);
      chk("wrap_rdy_a", rdy_a, 5);
      chk("wrap_rd_b", {16'b0, rd_b}, 32'hA55A);

      // Second edge while busy is ignored
      txn(1'b1, 1'b0, 16'h1234, 16'h0000, 1);
      chk("dbl_nrdy_a", n_a, 1);
      chk("dbl_nrdy_b", n_b, 1);
      chk("dbl_data_b", {16'b0, rd_b}, 32'hBEEF);

      // Reset during the high-byte write phase aborts the access
      prev = mem_a[16'h2001];
      txn(1'b1, 1'b1, 16'h2000, 16'hCDAB, 2);
      chk("abort_mem_lo", {24'b0, mem_a[16'h2000]}, 32'hAB);
      chk("abort_mem_hi", {24'b0, mem_a[16'h2001]}, {24'b0, prev});
      chk("abort_nrdy_a", n_a, 0);
      chk("abort_nrdy_b", n_b, 0);
      chk("abort_idle_c3", {31'b0, log_busy[3]}, 32'h0);

      // Controller is usable again afterwards
      txn(1'b0, 1'b0, 16'h2000, 16'h0000, 0);
      chk("recover_data_a", {16'b0, rd_a}, 32'h00AB);
      chk("recover_rdy_b", rdy_b, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
